// File: rtl/mem_access_if.sv
// mem_access_if: groups the CPU request/response handshake and the data-memory
// word port of mem_access_unit into one bundle.
// Modports: slave = the load/store unit, master = the CPU/memory side driving it.
interface mem_access_if;
  // CPU request channel
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // CPU response channel
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  // Word-wide data memory port
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_wd, mem_we
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_wd, mem_we
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front-end between the CPU datapath and word-wide data memory.
// Ports: clk, rst (async active-high), bus (mem_access_if.slave: request, response, memory port).
// Latency from accept edge to resp_valid: fault 1, load/word store 2, byte/half store 3; one request in flight.
module mem_access_unit #(
  parameter int unsigned MEM_WORDS = 16000
) (
  input  logic         clk,
  input  logic         rst,
  mem_access_if.slave  bus
);

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] WRITE  = 3'd2;
  localparam logic [2:0] RMW_RD = 3'd3;
  localparam logic [2:0] RMW_WR = 3'd4;
  localparam logic [2:0] RESP   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        unsigned_q;
  logic [31:0] wdata_q;
  logic [31:0] merged_q;
  logic [31:0] rdata_q;
  logic        fault_q;

  logic        accept;
  logic        req_fault;
  logic [4:0]  lane_shift;
  logic [31:0] lane;
  logic [31:0] load_ext;
  logic [31:0] merged_d;

  assign accept = bus.req_valid && (state_q == IDLE);

  // Fault decision uses the live request so the fault path can skip memory entirely.
  always_comb begin
    req_fault = 1'b0;
    if (bus.req_size == 2'b11) req_fault = 1'b1;
    if (bus.req_size == 2'b01 && bus.req_addr[0]) req_fault = 1'b1;
    if (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) req_fault = 1'b1;
    if (bus.req_addr >= ADDR_LIMIT) req_fault = 1'b1;
  end

  // Little-endian lane select: byte k lives in bits [8k+7:8k].
  assign lane_shift = {addr_q[1:0], 3'b000};
  assign lane       = bus.mem_rd >> lane_shift;

  always_comb begin
    load_ext = lane;
    case (size_q)
      2'b00:   load_ext = unsigned_q ? {24'd0, lane[7:0]}   : {{24{lane[7]}}, lane[7:0]};
      2'b01:   load_ext = unsigned_q ? {16'd0, lane[15:0]}  : {{16{lane[15]}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  // Sub-word store: overwrite only the addressed lane of the word just read.
  always_comb begin
    merged_d = bus.mem_rd;
    if (size_q == 2'b00) merged_d[lane_shift +: 8] = wdata_q[7:0];
    else                 merged_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_fault)                  state_d = RESP;
          else if (!bus.req_we)           state_d = LOAD;
          else if (bus.req_size == 2'b10) state_d = WRITE;
          else                            state_d = RMW_RD;
        end
      end
      LOAD:    state_d = RESP;
      WRITE:   state_d = RESP;
      RMW_RD:  state_d = RMW_WR;
      RMW_WR:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response registers change only on entry to RESP, so they hold between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      wdata_q    <= '0;
      merged_q   <= '0;
      rdata_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q     <= bus.req_addr;
        size_q     <= bus.req_size;
        we_q       <= bus.req_we;
        unsigned_q <= bus.req_unsigned;
        wdata_q    <= bus.req_wdata;
        if (req_fault) begin
          rdata_q <= '0;
          fault_q <= 1'b1;
        end
      end
      case (state_q)
        LOAD: begin
          rdata_q <= load_ext;
          fault_q <= 1'b0;
        end
        RMW_RD: merged_q <= merged_d;
        WRITE, RMW_WR: begin
          rdata_q <= '0;
          fault_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_fault = fault_q;
  assign bus.mem_addr   = {addr_q[31:2], 2'b00};
  // Write strobe decoded from the registered state only; async reset drops it at once.
  assign bus.mem_we     = (state_q == WRITE) || (state_q == RMW_WR);
  assign bus.mem_wd     = (state_q == WRITE)  ? wdata_q  :
                          (state_q == RMW_WR) ? merged_q : 32'd0;

  // we_q is kept for debug visibility of the accepted request.
  logic unused_we;
  assign unused_we = we_q;

endmodule
